// File: rtl/capi_command_issue.sv
// Issues CAPI PSL commands from a tag pool under a credit budget.
// Command bus is registered (1-cycle latency); cmd_ready_out drops when out of credits or tags.
package capi_command_issue_pkg;
    localparam logic [0:2] ABT_STRICT = 3'd0;
    localparam logic [0:2] ABT_ABORT  = 3'd1;
    localparam logic [0:2] ABT_PAGE   = 3'd2;
    localparam logic [0:2] ABT_PREF   = 3'd3;
    localparam logic [0:2] ABT_SPEC   = 3'd4;

    localparam logic [0:7] INVALID_TAG = 8'hFF;

    // Each *_parity is one bit covering the whole field that precedes it.
    typedef struct packed {
        logic        valid;
        logic [0:12] command;
        logic        command_parity;
        logic [0:63] address;
        logic        address_parity;
        logic [0:11] size;
        logic [0:7]  tag;
        logic        tag_parity;
        logic [0:2]  abt;
        logic [0:15] context_handle;
    } CommandInterfaceOutput;
endpackage

module capi_command_issue
    import capi_command_issue_pkg::*;
#(
    parameter int         NUM_TAGS    = 32,
    parameter int         MAX_CREDITS = 64,
    parameter bit         ODD_PARITY  = 1'b1,
    parameter logic [0:2] ABT_MODE    = ABT_PREF
) (
    input  logic                  clock,
    input  logic                  rstn,
    input  logic                  enabled_in,
    input  logic [7:0]            room_in,
    input  logic                  cmd_valid_in,
    input  logic [0:12]           cmd_command_in,
    input  logic [0:63]           cmd_address_in,
    input  logic [0:11]           cmd_size_in,
    output logic                  cmd_ready_out,
    input  logic                  rsp_valid_in,
    input  logic [7:0]            rsp_tag_in,
    output CommandInterfaceOutput command_out,
    output logic [7:0]            credits_out,
    output logic [8:0]            tags_free_out,
    output logic                  error_out
);

    localparam logic [7:0] MAX_C      = 8'(MAX_CREDITS);
    localparam logic [8:0] NUM_TAGS_C = 9'(NUM_TAGS);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_e;

    state_e                state_q, state_d;
    logic [NUM_TAGS-1:0]   free_q, free_d;
    logic [8:0]            tags_free_q, tags_free_d;
    logic [7:0]            credits_q, credits_d;
    logic                  error_q, error_d;
    CommandInterfaceOutput cmd_q, cmd_d;

    logic [NUM_TAGS-1:0]   alloc_mask, rsp_mask;
    logic [7:0]            alloc_tag;
    logic                  accept, rsp_hit, rsp_err;

    // FSM: state register
    always_ff @(posedge clock) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (enabled_in) state_d = ST_RUN;
            ST_RUN:   if (!enabled_in) state_d = ST_DRAIN;
            ST_DRAIN: begin
                if (tags_free_q == NUM_TAGS_C) begin
                    state_d = ST_IDLE;
                end else if (enabled_in) begin
                    state_d = ST_RUN;
                end
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        cmd_ready_out = cmd_valid_in && (state_q == ST_RUN)
                        && (credits_q != 8'd0) && (tags_free_q != 9'd0);
    end

    assign accept = cmd_valid_in & cmd_ready_out;

    // Descending scan so the lowest free tag wins; uses the registered pool,
    // so a tag returned this cycle is only allocatable next cycle.
    always_comb begin
        alloc_mask = '0;
        alloc_tag  = INVALID_TAG;
        for (int i = NUM_TAGS - 1; i >= 0; i--) begin
            if (free_q[i]) begin
                alloc_mask    = '0;
                alloc_mask[i] = 1'b1;
                alloc_tag     = 8'(i);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_TAGS; i++) begin
            rsp_mask[i] = (rsp_tag_in == 8'(i));
        end
    end

    // Out-of-range tags leave rsp_mask empty and so count as errors.
    assign rsp_hit = rsp_valid_in && (state_q != ST_IDLE) && (|(rsp_mask & ~free_q));
    assign rsp_err = rsp_valid_in && (state_q != ST_IDLE) && !rsp_hit;

    always_comb begin
        free_d      = free_q;
        tags_free_d = tags_free_q;
        credits_d   = credits_q;
        error_d     = error_q | rsp_err;
        if (state_q == ST_IDLE) begin
            if (enabled_in) begin
                free_d      = {NUM_TAGS{1'b1}};
                tags_free_d = NUM_TAGS_C;
                credits_d   = (room_in > MAX_C) ? MAX_C : room_in;
            end
        end else begin
            if (accept)  free_d = free_d & ~alloc_mask;
            if (rsp_hit) free_d = free_d | rsp_mask;
            tags_free_d = tags_free_q + 9'(rsp_hit) - 9'(accept);
            case ({accept, rsp_hit})
                2'b10:   credits_d = credits_q - 8'd1;
                2'b01:   credits_d = (credits_q < MAX_C) ? credits_q + 8'd1 : MAX_C;
                default: credits_d = credits_q;
            endcase
        end
    end

    always_comb begin
        cmd_d                = cmd_q;
        cmd_d.valid          = 1'b0;
        cmd_d.abt            = ABT_MODE;
        cmd_d.context_handle = 16'h0000;
        if (accept) begin
            cmd_d.valid          = 1'b1;
            cmd_d.command        = cmd_command_in;
            cmd_d.command_parity = (^cmd_command_in) ^ ODD_PARITY;
            cmd_d.address        = cmd_address_in;
            cmd_d.address_parity = (^cmd_address_in) ^ ODD_PARITY;
            cmd_d.size           = cmd_size_in;
            cmd_d.tag            = alloc_tag;
            cmd_d.tag_parity     = (^alloc_tag) ^ ODD_PARITY;
        end
    end

    always_ff @(posedge clock) begin
        if (!rstn) begin
            free_q               <= {NUM_TAGS{1'b1}};
            tags_free_q          <= NUM_TAGS_C;
            credits_q            <= 8'd0;
            error_q              <= 1'b0;
            cmd_q.valid          <= 1'b0;
            cmd_q.command        <= '0;
            cmd_q.command_parity <= ODD_PARITY;
            cmd_q.address        <= '0;
            cmd_q.address_parity <= ODD_PARITY;
            cmd_q.size           <= '0;
            cmd_q.tag            <= INVALID_TAG;
            cmd_q.tag_parity     <= (^INVALID_TAG) ^ ODD_PARITY;
            cmd_q.abt            <= ABT_MODE;
            cmd_q.context_handle <= 16'h0000;
        end else begin
            free_q      <= free_d;
            tags_free_q <= tags_free_d;
            credits_q   <= credits_d;
            error_q     <= error_d;
            cmd_q       <= cmd_d;
        end
    end

    assign command_out   = cmd_q;
    assign credits_out   = credits_q;
    assign tags_free_out = tags_free_q;
    assign error_out     = error_q;

endmodule

// File: tb/tb_capi_command_issue.sv
// Directed vector table plus hand-written sequences for capi_command_issue.
module tb_capi_command_issue;
    import capi_command_issue_pkg::*;

    logic                  clock = 1'b0;
    logic                  rstn;
    logic                  enabled_in;
    logic [7:0]            room_in;
    logic                  cmd_valid_in;
    logic [0:12]           cmd_command_in;
    logic [0:63]           cmd_address_in;
    logic [0:11]           cmd_size_in;
    logic                  cmd_ready_out;
    logic                  rsp_valid_in;
    logic [7:0]            rsp_tag_in;
    CommandInterfaceOutput command_out;
    logic [7:0]            credits_out;
    logic [8:0]            tags_free_out;
    logic                  error_out;

    int checks = 0;
    int errors = 0;

    capi_command_issue dut (
        .clock          (clock),
        .rstn           (rstn),
        .enabled_in     (enabled_in),
        .room_in        (room_in),
        .cmd_valid_in   (cmd_valid_in),
        .cmd_command_in (cmd_command_in),
        .cmd_address_in (cmd_address_in),
        .cmd_size_in    (cmd_size_in),
        .cmd_ready_out  (cmd_ready_out),
        .rsp_valid_in   (rsp_valid_in),
        .rsp_tag_in     (rsp_tag_in),
        .command_out    (command_out),
        .credits_out    (credits_out),
        .tags_free_out  (tags_free_out),
        .error_out      (error_out)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        en;
        logic [7:0]  room;
        logic        cv;
        logic [12:0] cmd;
        logic [63:0] addr;
        logic        rv;
        logic [7:0]  rt;
        logic        e_rdy;
        logic        e_vld;
        logic [7:0]  e_tag;
        logic [7:0]  e_cr;
        logic [8:0]  e_free;
        logic        e_err;
    } vec_t;

    vec_t vecs[19];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic en, input logic [7:0] room, input logic cv,
                         input logic [12:0] cmd, input logic [63:0] addr,
                         input logic rv, input logic [7:0] rt);
        @(negedge clock);
        enabled_in     = en;
        room_in        = room;
        cmd_valid_in   = cv;
        cmd_command_in = cmd;
        cmd_address_in = addr;
        cmd_size_in    = 12'h040;
        rsp_valid_in   = rv;
        rsp_tag_in     = rt;
    endtask

    task automatic check_regs(input string pfx, input logic vld, input logic [7:0] tag,
                              input logic [7:0] cr, input logic [8:0] fr, input logic err);
        chk({pfx, " valid"},     64'(command_out.valid), 64'(vld));
        chk({pfx, " tag"},       64'(command_out.tag),   64'(tag));
        chk({pfx, " credits"},   64'(credits_out),       64'(cr));
        chk({pfx, " tags_free"}, 64'(tags_free_out),     64'(fr));
        chk({pfx, " error"},     64'(error_out),         64'(err));
    endtask

    initial begin
        //          en room   cv cmd      addr          rv rt    rdy vld tag    cr    free  err
        vecs[0]  = '{1, 8'd2, 0, 13'h100, 64'h0,        0, 8'd0, 0,  0,  8'hFF, 8'd2, 9'd32, 0};
        vecs[1]  = '{1, 8'd2, 1, 13'h100, 64'h1000,     0, 8'd0, 1,  1,  8'd0,  8'd1, 9'd31, 0};
        vecs[2]  = '{1, 8'd2, 1, 13'h100, 64'h2000,     0, 8'd0, 1,  1,  8'd1,  8'd0, 9'd30, 0};
        vecs[3]  = '{1, 8'd2, 1, 13'h100, 64'h3000,     0, 8'd0, 0,  0,  8'd1,  8'd0, 9'd30, 0};
        vecs[4]  = '{1, 8'd2, 1, 13'h100, 64'h3000,     1, 8'd0, 0,  0,  8'd1,  8'd1, 9'd31, 0};
        vecs[5]  = '{1, 8'd2, 1, 13'h100, 64'h3000,     0, 8'd0, 1,  1,  8'd0,  8'd0, 9'd30, 0};
        vecs[6]  = '{1, 8'd2, 0, 13'h100, 64'h0,        1, 8'd5, 0,  0,  8'd0,  8'd0, 9'd30, 1};
        vecs[7]  = '{1, 8'd2, 0, 13'h100, 64'h0,        1, 8'd1, 0,  0,  8'd0,  8'd1, 9'd31, 1};
        vecs[8]  = '{1, 8'd2, 1, 13'h100, 64'h4000,     1, 8'd0, 1,  1,  8'd1,  8'd1, 9'd31, 1};
        vecs[9]  = '{1, 8'd2, 1, 13'h100, 64'h5000,     0, 8'd0, 1,  1,  8'd0,  8'd0, 9'd30, 1};
        vecs[10] = '{0, 8'd2, 1, 13'h100, 64'h6000,     0, 8'd0, 0,  0,  8'd0,  8'd0, 9'd30, 1};
        vecs[11] = '{0, 8'd2, 1, 13'h100, 64'h6000,     1, 8'd1, 0,  0,  8'd0,  8'd1, 9'd31, 1};
        vecs[12] = '{0, 8'd2, 1, 13'h100, 64'h6000,     1, 8'd0, 0,  0,  8'd0,  8'd2, 9'd32, 1};
        vecs[13] = '{0, 8'd2, 0, 13'h100, 64'h0,        0, 8'd0, 0,  0,  8'd0,  8'd2, 9'd32, 1};
        vecs[14] = '{1, 8'd5, 0, 13'h007, 64'h0,        0, 8'd0, 0,  0,  8'd0,  8'd5, 9'd32, 1};
        vecs[15] = '{1, 8'd5, 1, 13'h007, 64'h0,        0, 8'd0, 1,  1,  8'd0,  8'd4, 9'd31, 1};
        vecs[16] = '{1, 8'd5, 1, 13'h007, 64'h0,        0, 8'd0, 1,  1,  8'd1,  8'd3, 9'd30, 1};
        vecs[17] = '{1, 8'd5, 1, 13'h007, 64'h0,        0, 8'd0, 1,  1,  8'd2,  8'd2, 9'd29, 1};
        vecs[18] = '{1, 8'd5, 1, 13'h007, 64'h1,        0, 8'd0, 1,  1,  8'd3,  8'd1, 9'd28, 1};

        rstn           = 1'b0;
        enabled_in     = 1'b0;
        room_in        = 8'd0;
        cmd_valid_in   = 1'b0;
        cmd_command_in = '0;
        cmd_address_in = '0;
        cmd_size_in    = '0;
        rsp_valid_in   = 1'b0;
        rsp_tag_in     = 8'd0;
        repeat (2) @(posedge clock);
        #1;
        check_regs("reset", 1'b0, 8'hFF, 8'd0, 9'd32, 1'b0);
        chk("reset command",      64'(command_out.command),        64'h0);
        chk("reset address",      64'(command_out.address),        64'h0);
        chk("reset cmd_parity",   64'(command_out.command_parity), 64'h1);
        chk("reset addr_parity",  64'(command_out.address_parity), 64'h1);
        chk("reset tag_parity",   64'(command_out.tag_parity),     64'h1);
        chk("reset ready",        64'(cmd_ready_out),              64'h0);

        @(negedge clock);
        rstn = 1'b1;
        for (int i = 0; i < 19; i++) begin
            drive(vecs[i].en, vecs[i].room, vecs[i].cv, vecs[i].cmd, vecs[i].addr,
                  vecs[i].rv, vecs[i].rt);
            #1;
            chk($sformatf("v%0d ready", i), 64'(cmd_ready_out), 64'(vecs[i].e_rdy));
            @(posedge clock);
            #1;
            check_regs($sformatf("v%0d", i), vecs[i].e_vld, vecs[i].e_tag,
                       vecs[i].e_cr, vecs[i].e_free, vecs[i].e_err);
        end

        // Fields of the last issue: cmd 7, address 1, tag 3, odd parity.
        chk("par address",        64'(command_out.address),        64'h1);
        chk("par addr_parity",    64'(command_out.address_parity), 64'h0);
        chk("par tag_parity",     64'(command_out.tag_parity),     64'h1);
        chk("par cmd_parity",     64'(command_out.command_parity), 64'h0);
        chk("abt",                64'(command_out.abt),            64'(ABT_PREF));
        chk("context_handle",     64'(command_out.context_handle), 64'h0);
        chk("size",               64'(command_out.size),           64'h040);

        // Drop enable with tags outstanding, re-enable: back to RUN without reload.
        drive(1'b0, 8'd9, 1'b0, 13'h0, 64'h0, 1'b0, 8'd0);
        @(posedge clock); #1;
        check_regs("drain", 1'b0, 8'd3, 8'd1, 9'd28, 1'b1);
        drive(1'b1, 8'd9, 1'b1, 13'h0, 64'h0, 1'b0, 8'd0);
        #1;
        chk("drain ready", 64'(cmd_ready_out), 64'h0);
        @(posedge clock); #1;
        check_regs("rerun", 1'b0, 8'd3, 8'd1, 9'd28, 1'b1);
        drive(1'b1, 8'd9, 1'b1, 13'h0, 64'h0, 1'b0, 8'd0);
        #1;
        chk("rerun ready", 64'(cmd_ready_out), 64'h1);
        @(posedge clock); #1;
        check_regs("rerun issue", 1'b1, 8'd4, 8'd0, 9'd27, 1'b1);

        // Reset mid-RUN with tags outstanding.
        drive(1'b1, 8'd9, 1'b1, 13'h0, 64'h0, 1'b0, 8'd0);
        rstn = 1'b0;
        @(posedge clock); #1;
        check_regs("midrst", 1'b0, 8'hFF, 8'd0, 9'd32, 1'b0);

        // Responses in IDLE are ignored.
        drive(1'b0, 8'd9, 1'b0, 13'h0, 64'h0, 1'b1, 8'd3);
        rstn = 1'b1;
        @(posedge clock); #1;
        check_regs("idle rsp", 1'b0, 8'hFF, 8'd0, 9'd32, 1'b0);

        // Initial credits clamp to MAX_CREDITS.
        drive(1'b1, 8'd200, 1'b0, 13'h0, 64'h0, 1'b0, 8'd0);
        @(posedge clock); #1;
        chk("clamp credits", 64'(credits_out), 64'd64);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
